// File: rtl/wam_ctl.sv
// Whack-a-mole session sequencer: IDLE -> countdown -> timed round (pausable) -> game over.
// Optional build macro WAM_CTL_HITBONUS_EN: a successful hit in PLAY adds one second.
module wam_ctl #(
    parameter int TICKS_PER_SEC = 95,
    parameter int CNTDN_SEC     = 3,
    parameter int ROUND_SEC     = 60
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_pse,
    input  logic       hit_any,
    output logic       run,
    output logic       gen_clr,
    output logic [6:0] time_left,
    output logic [2:0] phase,
    output logic       over
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CNTDN = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int          TW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]  ROUND_T  = 7'(ROUND_SEC);
    localparam logic [6:0]  CNTDN_T  = 7'(CNTDN_SEC);

    logic [2:0]    state_q, state_d;
    logic [6:0]    time_left_q, time_left_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d, tick_nxt;
    logic          run_q, run_d, gen_clr_q, gen_clr_d, over_q, over_d;
    logic          start_prev_q, pse_prev_q;
    logic          start_edge, pse_edge, boundary;

`ifndef WAM_CTL_HITBONUS_EN
    logic unused_hit;
    assign unused_hit = hit_any;
`endif

    always_comb begin
        start_edge  = btn_start & ~start_prev_q;
        pse_edge    = btn_pse & ~pse_prev_q;
        boundary    = tick && (tick_cnt_q == TICK_MAX);
        tick_nxt    = boundary ? '0 : tick_cnt_q + 1'b1;
        state_d     = state_q;
        time_left_d = time_left_q;
        tick_cnt_d  = tick_cnt_q;
        gen_clr_d   = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    state_d     = S_CNTDN;
                    time_left_d = CNTDN_T;
                    tick_cnt_d  = '0;
                    gen_clr_d   = 1'b1;
                end
            end
            S_CNTDN: begin
                if (tick) tick_cnt_d = tick_nxt;
                if (boundary) begin
                    if (time_left_q == 7'd1) begin
                        state_d     = S_PLAY;
                        time_left_d = ROUND_T;
                    end else begin
                        time_left_d = time_left_q - 7'd1;
                    end
                end
            end
            S_PLAY: begin
                // A pause edge swallows any tick (and hit) arriving in the same cycle.
                if (pse_edge) begin
                    state_d = S_PAUSE;
                end else begin
                    if (tick) tick_cnt_d = tick_nxt;
`ifdef WAM_CTL_HITBONUS_EN
                    if (hit_any && !boundary)
                        time_left_d = (time_left_q >= ROUND_T) ? ROUND_T : time_left_q + 7'd1;
                    else if (boundary && !hit_any)
`else
                    if (boundary)
`endif
                    begin
                        if (time_left_q == 7'd1) begin
                            state_d     = S_OVER;
                            time_left_d = 7'd0;
                        end else begin
                            time_left_d = time_left_q - 7'd1;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (start_edge) begin
                    state_d     = S_IDLE;
                    time_left_d = ROUND_T;
                    tick_cnt_d  = '0;
                end else if (pse_edge) begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d     = S_IDLE;
                time_left_d = ROUND_T;
                tick_cnt_d  = '0;
            end
        endcase
        run_d  = (state_d == S_PLAY);
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            time_left_q  <= ROUND_T;
            tick_cnt_q   <= '0;
            run_q        <= 1'b0;
            gen_clr_q    <= 1'b0;
            over_q       <= 1'b0;
            // Track button levels through reset so a button held across clr gives no edge.
            start_prev_q <= btn_start;
            pse_prev_q   <= btn_pse;
        end else begin
            state_q      <= state_d;
            time_left_q  <= time_left_d;
            tick_cnt_q   <= tick_cnt_d;
            run_q        <= run_d;
            gen_clr_q    <= gen_clr_d;
            over_q       <= over_d;
            start_prev_q <= btn_start;
            pse_prev_q   <= btn_pse;
        end
    end

    assign run       = run_q;
    assign gen_clr   = gen_clr_q;
    assign time_left = time_left_q;
    assign phase     = state_q;
    assign over      = over_q;
endmodule

// File: tb/tb_wam_ctl.sv
// Directed bench for wam_ctl with TICKS_PER_SEC=4, CNTDN_SEC=3, ROUND_SEC=5.
module tb_wam_ctl;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       tick = 1'b0, btn_start = 1'b0, btn_pse = 1'b0, hit_any = 1'b0;
    logic       run, gen_clr, over;
    logic [6:0] time_left;
    logic [2:0] phase;
    int         checks = 0;
    int         failures = 0;

    wam_ctl #(.TICKS_PER_SEC(4), .CNTDN_SEC(3), .ROUND_SEC(5)) dut (
        .clk(clk), .clr(clr), .tick(tick), .btn_start(btn_start), .btn_pse(btn_pse),
        .hit_any(hit_any), .run(run), .gen_clr(gen_clr), .time_left(time_left),
        .phase(phase), .over(over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_round();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        ticks(12);
    endtask

    initial begin
        step(); step();
        clr = 1'b0;
        step();
        chk("rst_phase", phase, 0);
        chk("rst_run", run, 0);
        chk("rst_genclr", gen_clr, 0);
        chk("rst_over", over, 0);
        chk("rst_tl", time_left, 5);

        // 1: start -> countdown -> play
        btn_start = 1'b1;
        step();
        chk("t1_genclr", gen_clr, 1);
        chk("t1_phase", phase, 1);
        chk("t1_tl", time_left, 3);
        step();
        chk("t1_genclr_pulse", gen_clr, 0);
        btn_start = 1'b0;
        ticks(4);
        chk("t1_cd_tl", time_left, 2);
        ticks(8);
        chk("t1_play_phase", phase, 2);
        chk("t1_play_run", run, 1);
        chk("t1_play_tl", time_left, 5);

        // 2: full round to OVER, then restart
        for (int k = 1; k <= 4; k++) begin
            ticks(4);
            chk("t2_tl", time_left, 5 - k);
        end
        ticks(3);
        chk("t2_pre_phase", phase, 2);
        ticks(1);
        chk("t2_over_phase", phase, 4);
        chk("t2_over", over, 1);
        chk("t2_run", run, 0);
        chk("t2_tl0", time_left, 0);
        ticks(5);
        chk("t2_tl_hold", time_left, 0);
        btn_start = 1'b1;
        step();
        chk("t2_restart_phase", phase, 1);
        chk("t2_restart_genclr", gen_clr, 1);
        btn_start = 1'b0;
        ticks(12);
        chk("t2_replay", phase, 2);

        // 3: pause coincident with tick drops the tick
        ticks(2);
        tick = 1'b1; btn_pse = 1'b1;
        step();
        tick = 1'b0; btn_pse = 1'b0;
        chk("t3_pause_phase", phase, 3);
        chk("t3_pause_run", run, 0);
        ticks(10);
        chk("t3_frozen_tl", time_left, 5);
        btn_pse = 1'b1;
        step();
        btn_pse = 1'b0;
        chk("t3_resume", phase, 2);
        ticks(1);
        chk("t3_no_dec_yet", time_left, 5);
        ticks(1);
        chk("t3_dec", time_left, 4);

        // 4: abort from PAUSE, start beats pause
        btn_pse = 1'b1;
        step();
        btn_pse = 1'b0;
        chk("t4_paused", phase, 3);
        btn_start = 1'b1; btn_pse = 1'b1;
        step();
        chk("t4_phase", phase, 0);
        chk("t4_tl", time_left, 5);
        chk("t4_genclr", gen_clr, 0);
        btn_start = 1'b0; btn_pse = 1'b0;
        step();

        // 5: clr mid-round with start held
        start_round();
        ticks(12);
        chk("t5_tl2", time_left, 2);
        btn_start = 1'b1; clr = 1'b1;
        step();
        chk("t5_phase", phase, 0);
        chk("t5_tl", time_left, 5);
        chk("t5_run", run, 0);
        clr = 1'b0;
        step(); step();
        chk("t5_held_idle", phase, 0);
        chk("t5_held_genclr", gen_clr, 0);
        btn_start = 1'b0;
        step();

        // 6: hit bonus (or its absence)
        start_round();
        hit_any = 1'b1;
        step();
        hit_any = 1'b0;
        chk("t6_sat", time_left, 5);
        ticks(8);
        chk("t6_tl3", time_left, 3);
        hit_any = 1'b1;
        step();
        hit_any = 1'b0;
`ifdef WAM_CTL_HITBONUS_EN
        chk("t6_bonus", time_left, 4);
        ticks(12);
`else
        chk("t6_bonus", time_left, 3);
        ticks(8);
`endif
        chk("t6_tl1", time_left, 1);
        ticks(3);
        tick = 1'b1; hit_any = 1'b1;
        step();
        tick = 1'b0; hit_any = 1'b0;
`ifdef WAM_CTL_HITBONUS_EN
        chk("t6_bnd_tl", time_left, 1);
        chk("t6_bnd_phase", phase, 2);
`else
        chk("t6_bnd_tl", time_left, 0);
        chk("t6_bnd_phase", phase, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
